// File: rtl/led_pwm_pkg.sv
// Shared mode encodings, breathe state and register-map helpers for the
// N-channel PWM LED controller.
package led_pwm_pkg;

    localparam logic [1:0] MODE_STATIC  = 2'd0;
    localparam logic [1:0] MODE_BLINK   = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;

    typedef enum logic {
        BR_UP   = 1'b0,
        BR_DOWN = 1'b1
    } breathe_state_t;

    function automatic int duty_addr(input int i);
        return i;
    endfunction

    function automatic int mode_addr(input int n_ch, input int i);
        return n_ch + i;
    endfunction

    function automatic int ctrl_addr(input int n_ch);
        return 2 * n_ch;
    endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// One PWM channel: pending/active duty and mode, blink and breathe sequencing,
// registered compare against the shared PWM counter.
module led_pwm_chan
    import led_pwm_pkg::*;
#(
    parameter int PWM_W   = 8,
    parameter int BLINK_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wrap,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic             duty_wr,
    input  logic [PWM_W-1:0] duty_data,
    input  logic             mode_wr,
    input  logic [1:0]       mode_data,
    output logic             pwm
);

    localparam logic [BLINK_W-1:0] BLINK_LAST = {BLINK_W{1'b1}} - BLINK_W'(1);

    logic [PWM_W-1:0]   duty_pend_reg, duty_act_reg, level_reg;
    logic [1:0]         mode_pend_reg, mode_act_reg;
    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               phase_on_reg;
    logic               pwm_reg;
    breathe_state_t     state_reg;

    logic [PWM_W-1:0]   duty_pend_next, duty_act_next, eff_duty;
    logic [1:0]         mode_pend_next, mode_act_next;
    logic               copy;

    // A write in the same cycle as a copy is forwarded, so it lands at that copy.
    always_comb begin
        duty_pend_next = duty_wr ? duty_data : duty_pend_reg;
        mode_pend_next = mode_wr ? mode_data : mode_pend_reg;
        copy           = wrap | ~en;
        duty_act_next  = copy ? duty_pend_next : duty_act_reg;
        mode_act_next  = copy ? mode_pend_next : mode_act_reg;
        eff_duty       = (mode_act_reg == MODE_BREATHE) ? level_reg : duty_act_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_pend_reg <= '0;
            duty_act_reg  <= '0;
            mode_pend_reg <= MODE_STATIC;
            mode_act_reg  <= MODE_STATIC;
            blink_cnt_reg <= '0;
            phase_on_reg  <= 1'b1;
            level_reg     <= '0;
            state_reg     <= BR_UP;
            pwm_reg       <= 1'b0;
        end else begin
            duty_pend_reg <= duty_pend_next;
            mode_pend_reg <= mode_pend_next;
            duty_act_reg  <= duty_act_next;
            mode_act_reg  <= mode_act_next;
            pwm_reg       <= en & phase_on_reg & (pwm_cnt < eff_duty);

            if (!en || (mode_act_next != mode_act_reg)) begin
                blink_cnt_reg <= '0;
                phase_on_reg  <= 1'b1;
                level_reg     <= '0;
                state_reg     <= BR_UP;
            end else if (wrap) begin
                case (mode_act_reg)
                    MODE_BLINK: begin
                        if (blink_cnt_reg == BLINK_LAST) begin
                            blink_cnt_reg <= '0;
                            phase_on_reg  <= ~phase_on_reg;
                        end else begin
                            blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
                        end
                    end
                    MODE_BREATHE: begin
                        // Turn-around steps immediately so the peak and the floor last one period.
                        if (level_reg > duty_act_next) begin
                            level_reg <= duty_act_next;
                            state_reg <= BR_DOWN;
                        end else if (state_reg == BR_UP) begin
                            if (level_reg == duty_act_next) begin
                                state_reg <= BR_DOWN;
                                if (level_reg != '0)
                                    level_reg <= level_reg - PWM_W'(1);
                            end else begin
                                level_reg <= level_reg + PWM_W'(1);
                            end
                        end else begin
                            if (level_reg == '0) begin
                                state_reg <= BR_UP;
                                if (duty_act_next != '0)
                                    level_reg <= PWM_W'(1);
                            end else begin
                                level_reg <= level_reg - PWM_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pwm = pwm_reg;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Register-programmable N-channel PWM LED controller: CTRL register, address
// decode, prescaler and shared PWM counter feeding one led_pwm_chan per channel.
module led_pwm_ctrl
    import led_pwm_pkg::*;
#(
    parameter int N_CH    = 3,
    parameter int PWM_W   = 8,
    parameter int PRE_W   = 16,
    parameter int BLINK_W = 6,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    output logic [N_CH-1:0]   pwm_out,
    output logic              period_tick
);

    localparam logic [PWM_W-1:0] CNT_MAX = '1;

    logic             en_reg;
    logic [PRE_W-1:0] prescale_reg, pre_cnt_reg;
    logic [PWM_W-1:0] pwm_cnt_reg;
    logic             period_tick_reg;

    logic             ctrl_wr, en_next, run, tick, wrap;
    logic [N_CH-1:0]  duty_wr, mode_wr;
    logic             unused_data;

    // run drops in the cycle EN is being cleared, so outputs go low one cycle later.
    assign ctrl_wr     = wr_en && (wr_addr == ADDR_W'(ctrl_addr(N_CH)));
    assign en_next     = ctrl_wr ? wr_data[0] : en_reg;
    assign run         = en_reg & en_next;
    assign tick        = run && (pre_cnt_reg == prescale_reg);
    assign wrap        = tick && (pwm_cnt_reg == CNT_MAX);
    assign unused_data = ^wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_reg          <= 1'b0;
            prescale_reg    <= '0;
            pre_cnt_reg     <= '0;
            pwm_cnt_reg     <= '0;
            period_tick_reg <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en_reg       <= wr_data[0];
                prescale_reg <= wr_data[PRE_W+15:16];
            end
            period_tick_reg <= wrap;
            if (!run) begin
                pre_cnt_reg <= '0;
                pwm_cnt_reg <= '0;
            end else begin
                // A prescale shrunk below pre_cnt restarts the count silently.
                if (tick || (pre_cnt_reg > prescale_reg))
                    pre_cnt_reg <= '0;
                else
                    pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
                if (tick)
                    pwm_cnt_reg <= pwm_cnt_reg + PWM_W'(1);
            end
        end
    end

    assign period_tick = period_tick_reg;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
            assign duty_wr[gi] = wr_en && (wr_addr == ADDR_W'(duty_addr(gi)));
            assign mode_wr[gi] = wr_en && (wr_addr == ADDR_W'(mode_addr(N_CH, gi)));

            led_pwm_chan #(
                .PWM_W   (PWM_W),
                .BLINK_W (BLINK_W)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .en        (run),
                .wrap      (wrap),
                .pwm_cnt   (pwm_cnt_reg),
                .duty_wr   (duty_wr[gi]),
                .duty_data (wr_data[PWM_W-1:0]),
                .mode_wr   (mode_wr[gi]),
                .mode_data (wr_data[1:0]),
                .pwm       (pwm_out[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl (N_CH=3, PWM_W=8, BLINK_W=2): per-period high
// counts and edge timing against hand-computed values.
module tb_led_pwm_ctrl;

    localparam int N_CH    = 3;
    localparam int PWM_W   = 8;
    localparam int PRE_W   = 16;
    localparam int BLINK_W = 2;
    localparam int ADDR_W  = 4;

    localparam int A_MODE0 = 3;
    localparam int A_MODE2 = 5;
    localparam int A_CTRL  = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [N_CH-1:0]   pwm_out;
    logic              period_tick;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    led_pwm_ctrl #(
        .N_CH    (N_CH),
        .PWM_W   (PWM_W),
        .PRE_W   (PRE_W),
        .BLINK_W (BLINK_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input int a, input int unsigned d);
        wr_addr = ADDR_W'(a);
        wr_data = d;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    // Samples from the current cycle until the next period_tick; optional write at cycle wr_at.
    task automatic measure(input int budget, input int wr_at, input int a, input int unsigned d,
                           output int cycles, output int hi0, output int hi1, output int hi2,
                           output int first1);
        cycles = 0; hi0 = 0; hi1 = 0; hi2 = 0; first1 = -1;
        do begin
            hi0 += int'(pwm_out[0]);
            hi1 += int'(pwm_out[1]);
            hi2 += int'(pwm_out[2]);
            if (pwm_out[1] && first1 < 0) first1 = cycles;
            if (cycles == wr_at) begin
                wr_addr = ADDR_W'(a);
                wr_data = d;
                wr_en   = 1'b1;
            end
            cycles++;
            step();
            wr_en = 1'b0;
        end while (!period_tick && cycles < budget);
        check_eq("tick_seen", int'(period_tick), 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, h0, h1, h2, f1, s0, s2, n_tick, n_hi;
        int bl_exp[7]  = '{128, 128, 128, 0, 0, 0, 128};
        int br_exp[17] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 2, 1, 0, 1};

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) step();
        check_eq("rst_pwm_out", int'(pwm_out), 0);
        check_eq("rst_period_tick", int'(period_tick), 0);
        rst = 1'b0;

        n_tick = 0; n_hi = 0;
        for (int i = 0; i < 1000; i++) begin
            n_tick += int'(period_tick);
            n_hi   += int'(|pwm_out);
            step();
        end
        check_eq("idle_ticks", n_tick, 0);
        check_eq("idle_pwm_high", n_hi, 0);

        // Static duties 64 / 0 / 255, prescale 0.
        reg_write(0, 64); reg_write(1, 0); reg_write(2, 255); reg_write(A_CTRL, 1);
        measure(600, -1, 0, 0, cyc, h0, h1, h2, f1);
        check_eq("first_period_len", cyc, 256);
        check_eq("first_duty64", h0, 64);
        check_eq("first_duty0", h1, 0);
        check_eq("first_duty255", h2, 255);
        measure(300, -1, 0, 0, cyc, h0, h1, h2, f1);
        check_eq("period_len", cyc, 256);
        check_eq("duty64", h0, 64);
        check_eq("duty255", h2, 255);

        // DUTY[1]=200 written at pwm_cnt=100 waits for the wrap.
        measure(300, 100, 1, 200, cyc, h0, h1, h2, f1);
        check_eq("midwrite_period_len", cyc, 256);
        check_eq("midwrite_old_duty", h1, 0);
        measure(300, -1, 0, 0, cyc, h0, h1, h2, f1);
        check_eq("new_duty200", h1, 200);
        check_eq("new_duty_first_high", f1, 1);

        // Blink on channel 2: 3 periods on, 3 off.
        reg_write(A_MODE2, 1); reg_write(2, 128);
        measure(300, -1, 0, 0, cyc, h0, h1, h2, f1);
        check_eq("blink_setup_len", cyc, 254);
        for (int p = 0; p < 7; p++) begin
            measure(300, -1, 0, 0, cyc, h0, h1, h2, f1);
            check_eq($sformatf("blink_p%0d", p), h2, bl_exp[p]);
        end

        // PRESCALE=3: 1024-cycle periods, six periods hold three blink-on periods.
        reg_write(A_CTRL, 32'h0003_0001);
        measure(1100, -1, 0, 0, cyc, h0, h1, h2, f1);
        s0 = 0; s2 = 0;
        for (int p = 0; p < 6; p++) begin
            measure(1100, -1, 0, 0, cyc, h0, h1, h2, f1);
            check_eq($sformatf("pre3_len_p%0d", p), cyc, 1024);
            s0 += h0;
            s2 += h2;
        end
        check_eq("pre3_duty64_sum", s0, 1536);
        check_eq("pre3_blink_sum", s2, 1536);
        reg_write(A_CTRL, 1);
        measure(1100, -1, 0, 0, cyc, h0, h1, h2, f1);

        // Breathe on channel 0 with DUTY 4, lowered to 2 while at level 4.
        reg_write(A_MODE0, 2); reg_write(0, 4);
        measure(300, -1, 0, 0, cyc, h0, h1, h2, f1);
        for (int p = 0; p < 17; p++) begin
            measure(300, (p == 12) ? 128 : -1, 0, 2, cyc, h0, h1, h2, f1);
            check_eq($sformatf("breathe_p%0d", p), h0, br_exp[p]);
        end

        // Clear EN mid-period, then re-enable.
        repeat (10) step();
        check_eq("pre_disable_ch1", int'(pwm_out[1]), 1);
        reg_write(A_CTRL, 0);
        check_eq("disable_pwm_out", int'(pwm_out), 0);
        n_tick = 0; n_hi = 0;
        for (int i = 0; i < 50; i++) begin
            n_tick += int'(period_tick);
            n_hi   += int'(|pwm_out);
            step();
        end
        check_eq("disabled_ticks", n_tick, 0);
        check_eq("disabled_pwm_high", n_hi, 0);
        reg_write(A_CTRL, 1);
        measure(300, -1, 0, 0, cyc, h0, h1, h2, f1);
        check_eq("reenable_period_len", cyc, 256);
        check_eq("reenable_duty200", h1, 200);
        check_eq("reenable_first_high", f1, 1);
        check_eq("reenable_breathe_l0", h0, 0);
        measure(300, -1, 0, 0, cyc, h0, h1, h2, f1);
        check_eq("reenable_breathe_l1", h0, 1);
        measure(300, -1, 0, 0, cyc, h0, h1, h2, f1);
        check_eq("reenable_breathe_l2", h0, 2);

        // Reset during breathe, then restart the sequence.
        repeat (50) step();
        rst = 1'b1;
        step();
        check_eq("midrst_pwm_out", int'(pwm_out), 0);
        check_eq("midrst_period_tick", int'(period_tick), 0);
        step();
        rst = 1'b0;
        reg_write(A_MODE0, 2); reg_write(0, 4); reg_write(A_CTRL, 1);
        for (int p = 0; p < 3; p++) begin
            measure(300, -1, 0, 0, cyc, h0, h1, h2, f1);
            check_eq($sformatf("post_rst_len_p%0d", p), cyc, 256);
            check_eq($sformatf("post_rst_breathe_p%0d", p), h0, p);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
